// File: rtl/channel_selector.sv
// channel_selector: picks one of CHANNELS valid/ready input channels and moves
// its words into a single registered output slot.
//   mode = 0 : manual, channel chosen by sel (illegal sel sets sticky err)
//   mode = 1 : round-robin scan, each grant lasts up to DWELL beats
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   d                 channel data, channel k at [k*WIDTH +: WIDTH]
//   valid_in/ready_in per-channel handshake (ready_in is combinational)
//   sel, mode         manual index, mode select
//   q, q_valid, q_ch  registered output word, its valid flag and source channel
//   q_ready           downstream accepts q this cycle
//   err               sticky illegal-sel flag
module channel_selector #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH*CHANNELS-1:0] d,
  input  logic [CHANNELS-1:0]       valid_in,
  output logic [CHANNELS-1:0]       ready_in,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  output logic [WIDTH-1:0]          q,
  output logic                      q_valid,
  input  logic                      q_ready,
  output logic [SEL_W-1:0]          q_ch,
  output logic                      err
);

  localparam logic [SEL_W:0]   ChanLim   = (SEL_W + 1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LastCh    = SEL_W'(CHANNELS - 1);
  localparam logic [7:0]       DwellLast = 8'(DWELL - 1);

  typedef enum logic [0:0] {StScan, StGrant} state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]  data_q;
  logic              valid_q;
  logic [SEL_W-1:0]  ch_q;
  logic              err_q;

  logic [SEL_W-1:0]  cur;
  logic [SEL_W-1:0]  ptr_inc;
  logic              sel_legal;
  logic              cur_open;
  logic              cur_valid;
  logic [WIDTH-1:0]  cur_data;
  logic              slot_free;
  logic              xfer;

  assign sel_legal = {1'b0, sel} < ChanLim;
  assign cur       = mode ? ptr_q : sel;
  // Round-robin only offers ready while granted; manual only for a legal index.
  assign cur_open  = mode ? (state_q == StGrant) : sel_legal;
  assign slot_free = !valid_q || q_ready;
  assign ptr_inc   = (ptr_q == LastCh) ? '0 : ptr_q + 1'b1;

  always_comb begin
    ready_in  = '0;
    cur_valid = 1'b0;
    cur_data  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (cur == SEL_W'(k)) begin
        ready_in[k] = rst_n && cur_open && slot_free;
        cur_valid   = valid_in[k];
        cur_data    = d[k*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer = cur_valid && cur_open && slot_free;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (!mode) begin
      // Manual mode parks the scanner; pointer keeps its place.
      state_d = StScan;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StScan: begin
          if (cur_valid) begin
            state_d = StGrant;
            cnt_d   = '0;
          end else begin
            ptr_d = ptr_inc;
          end
        end
        StGrant: begin
          if (!cur_valid) begin
            state_d = StScan;
            ptr_d   = ptr_inc;
            cnt_d   = '0;
          end else if (xfer) begin
            if (cnt_q == DwellLast) begin
              state_d = StScan;
              ptr_d   = ptr_inc;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
          // Valid but stalled by backpressure: dwell is not consumed.
        end
        default: state_d = StScan;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StScan;
      ptr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ch_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      if (xfer) begin
        data_q  <= cur_data;
        ch_q    <= cur;
        valid_q <= 1'b1;
      end else if (q_ready) begin
        valid_q <= 1'b0;
      end
      if (!mode && !sel_legal) begin
        err_q <= 1'b1;
      end
    end
  end

  assign q       = data_q;
  assign q_valid = valid_q;
  assign q_ch    = ch_q;
  assign err     = err_q;

endmodule

// File: tb/tb_channel_selector.sv
// Directed bench for channel_selector: default instance (4 channels) plus a
// 5-channel instance whose 3-bit select can reach an illegal index.
module tb_channel_selector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] d;
  logic [3:0]  valid_in;
  logic [3:0]  ready_in;
  logic [1:0]  sel;
  logic        mode;
  logic [7:0]  q;
  logic        q_valid;
  logic        q_ready;
  logic [1:0]  q_ch;
  logic        err;

  logic [39:0] d5;
  logic [4:0]  valid5;
  logic [4:0]  ready5;
  logic [2:0]  sel5;
  logic [7:0]  q5;
  logic        q_valid5;
  logic [2:0]  q_ch5;
  logic        err5;

  int checks = 0;
  int errors = 0;

  channel_selector u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d        (d),
    .valid_in (valid_in),
    .ready_in (ready_in),
    .sel      (sel),
    .mode     (mode),
    .q        (q),
    .q_valid  (q_valid),
    .q_ready  (q_ready),
    .q_ch     (q_ch),
    .err      (err)
  );

  channel_selector #(
    .WIDTH    (8),
    .CHANNELS (5),
    .SEL_W    (3),
    .DWELL    (4)
  ) u_dut5 (
    .clk      (clk),
    .rst_n    (rst_n),
    .d        (d5),
    .valid_in (valid5),
    .ready_in (ready5),
    .sel      (sel5),
    .mode     (1'b0),
    .q        (q5),
    .q_valid  (q_valid5),
    .q_ready  (1'b1),
    .q_ch     (q_ch5),
    .err      (err5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    mode     = 1'b0;
    sel      = 2'd0;
    valid_in = 4'b1111;
    q_ready  = 1'b1;
    d        = 32'h44332211;
    d5       = 40'h5544332211;
    valid5   = 5'b11111;
    sel5     = 3'd0;

    // Reset state; ready gated off even though manual ch0 is valid.
    step();
    check("rst_q", q, 0);
    check("rst_q_valid", q_valid, 0);
    check("rst_q_ch", q_ch, 0);
    check("rst_err", err, 0);
    check("rst_ready_in", ready_in, 0);

    // Manual select of channel 2.
    rst_n    = 1'b1;
    sel      = 2'd2;
    valid_in = 4'b0100;
    d        = 32'h00A50000;
    sel5     = 3'd5;
    #1;
    check("man_ready_in", ready_in, 4'b0100);
    check("ill_ready5", ready5, 0);
    step();
    check("man_q", q, 8'hA5);
    check("man_q_ch", q_ch, 2);
    check("man_q_valid", q_valid, 1);
    check("man_err", err, 0);
    check("ill_q_valid5", q_valid5, 0);
    check("ill_err5", err5, 1);
    valid_in = 4'b0000;
    sel5     = 3'd0;
    step();
    check("man_drain_valid", q_valid, 0);
    check("man_hold_q", q, 8'hA5);
    check("ill_err5_sticky", err5, 1);
    check("ill_recover_valid5", q_valid5, 1);
    sel5 = 3'd4;
    #1;
    check("last_ch_ready5", ready5, 5'b10000);
    step();
    check("last_ch_q5", q5, 8'h55);
    check("last_ch_qch5", q_ch5, 4);

    // Round-robin with all channels valid: 4 beats per channel, one scan gap.
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    mode     = 1'b1;
    valid_in = 4'b1111;
    d        = 32'h44332211;
    step();
    check("rr_first_ready", ready_in, 4'b0001);
    for (int i = 1; i <= 24; i++) begin
      logic        exp_v;
      logic [1:0]  exp_ch;
      logic [7:0]  exp_q;
      step();
      exp_v  = ((i - 1) % 5) != 4;
      exp_ch = 2'(((i - 1) / 5) % 4);
      exp_q  = 8'h11 * (8'(exp_ch) + 8'd1);
      check($sformatf("rr_valid_%0d", i), q_valid, exp_v);
      if (exp_v) begin
        check($sformatf("rr_ch_%0d", i), q_ch, exp_ch);
        check($sformatf("rr_q_%0d", i), q, exp_q);
      end
    end

    // Backpressure during a ch1 grant does not consume dwell.
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    valid_in = 4'b0010;
    d        = 32'h0000B000;
    step();
    step();
    check("bp_grant_ready", ready_in, 4'b0010);
    step();
    check("bp_q0", q, 8'hB0);
    check("bp_q0_valid", q_valid, 1);
    q_ready = 1'b0;
    d       = 32'h0000B100;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_stall_ready_%0d", i), ready_in, 0);
      step();
      check($sformatf("bp_hold_q_%0d", i), q, 8'hB0);
      check($sformatf("bp_hold_valid_%0d", i), q_valid, 1);
      check($sformatf("bp_hold_ch_%0d", i), q_ch, 1);
    end
    q_ready = 1'b1;
    #1;
    check("bp_resume_ready", ready_in, 4'b0010);
    step();
    check("bp_q1", q, 8'hB1);
    d = 32'h0000B200;
    step();
    check("bp_q2", q, 8'hB2);
    d = 32'h0000B300;
    step();
    check("bp_q3", q, 8'hB3);
    check("bp_q3_valid", q_valid, 1);
    check("bp_end_ready", ready_in, 0);
    step();
    check("bp_after_valid", q_valid, 0);

    // Asynchronous reset mid-grant with a word in q; scan restarts at ch0.
    valid_in = 4'b1111;
    d        = 32'h44332211;
    step();
    step();
    check("ar_pre_valid", q_valid, 1);
    check("ar_pre_ch", q_ch, 3);
    rst_n = 1'b0;
    #1;
    check("ar_q", q, 0);
    check("ar_q_valid", q_valid, 0);
    check("ar_q_ch", q_ch, 0);
    check("ar_ready_in", ready_in, 0);
    step();
    rst_n = 1'b1;
    step();
    check("ar_restart_ready", ready_in, 4'b0001);
    step();
    check("ar_restart_ch", q_ch, 0);
    check("ar_restart_q", q, 8'h11);
    check("ar_restart_valid", q_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
